// File: rtl/multi_stall_control_pkg.sv
// Shared types for the multi-cycle stall sequencer: datapath control enums, the control bundle
// struct, the idle bundle and the per-op stall length helper.
package multi_stall_control_pkg;

  typedef enum logic {DISABLE = 1'b0, ENABLE = 1'b1} control_e;

  typedef enum logic [1:0] {ALU_NOP, ALU_INC, ALU_DEC, ALU_ADD} alu_op_e;

  typedef enum logic [1:0] {ALU_FROM_ACC, ALU_FROM_CACHE, ALU_FROM_STACK} alu_src_e;

  typedef enum logic [1:0] {ACC_FROM_ALU, ACC_FROM_MEM, ACC_FROM_IMM} acc_src_e;

  typedef enum logic [1:0] {ADDR_FROM_PC, ADDR_FROM_ALU, ADDR_FROM_HEAD} mem_addr_e;

  typedef enum logic {MEM_FROM_ALU, MEM_FROM_ACC} mem_src_e;

  typedef enum logic [1:0] {MEM_NOP, MEM_READ, MEM_WRITE} mem_op_e;

  typedef enum logic {PC_INCREMENTED, PC_LOADED} pc_src_e;

  typedef enum logic {CORE_S, STALL_S} core_state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_CBF, OP_CBB, OP_POP, OP_PUSH, OP_ADD, OP_JMP
  } op_code_e;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_WAIT} stall_state_e;

  typedef struct packed {
    control_e    head_write;
    control_e    stack_write;
    control_e    acc_write;
    control_e    cache_write;
    control_e    pc_write;
    control_e    loader_select;
    alu_op_e     alu_op;
    alu_src_e    alu_src;
    acc_src_e    acc_src;
    mem_addr_e   mem_addr;
    mem_src_e    mem_src;
    mem_op_e     mem_op;
    pc_src_e     pc_src;
    core_state_e state;
  } control_bundle_s;

  localparam control_bundle_s IDLE_BUNDLE = '{
    head_write:    DISABLE,
    stack_write:   DISABLE,
    acc_write:     DISABLE,
    cache_write:   DISABLE,
    pc_write:      DISABLE,
    loader_select: DISABLE,
    alu_op:        ALU_NOP,
    alu_src:       ALU_FROM_ACC,
    acc_src:       ACC_FROM_ALU,
    mem_addr:      ADDR_FROM_PC,
    mem_src:       MEM_FROM_ALU,
    mem_op:        MEM_NOP,
    pc_src:        PC_INCREMENTED,
    state:         CORE_S
  };

  // Number of stall cycles following the primary cycle; 0 for ops that never stall.
  function automatic int unsigned stall_len(op_code_e op, int unsigned pc_bytes);
    int unsigned len;
    len = 0;
    if (op == OP_CBF || op == OP_CBB) len = pc_bytes - 1;
    else if (op == OP_POP) len = 1;
    return len;
  endfunction

endpackage

// File: rtl/multi_stall_control_if.sv
// Handshake bundle between core_control/memory (master) and the stall sequencer (slave).
interface multi_stall_control_if #(
  parameter int unsigned CNT_W = 3
);
  import multi_stall_control_pkg::*;

  logic            stall_req;
  op_code_e        instruction;
  logic            acc_zero;
  logic            mem_ready;
  logic            flush;
  control_bundle_s controls;
  logic            stall_active;
  logic            stall_done;
  logic [CNT_W-1:0] step;
  logic            seq_err;

  modport master (
    output stall_req, instruction, acc_zero, mem_ready, flush,
    input  controls, stall_active, stall_done, step, seq_err
  );

  modport slave (
    input  stall_req, instruction, acc_zero, mem_ready, flush,
    output controls, stall_active, stall_done, step, seq_err
  );

endinterface

// File: rtl/multi_stall_control_bundle_gen.sv
// Combinational decode of the latched op and step position into a datapath control bundle.
module stall_bundle_gen
  import multi_stall_control_pkg::*;
(
  input  op_code_e        op,
  input  logic            last,
  input  logic            hold,        // wait state or flush: nothing may commit this cycle
  input  logic            acc_zero_l,
  output control_bundle_s bundle
);

  // Fields common to every op first, then per-op overrides, then the commit mask.
  always_comb begin
    bundle          = IDLE_BUNDLE;
    bundle.acc_src  = ACC_FROM_ALU;
    bundle.state    = last ? CORE_S : STALL_S;
    bundle.pc_write = (last && !hold) ? ENABLE : DISABLE;
    unique case (op)
      OP_CBF: begin
        bundle.cache_write   = ENABLE;
        bundle.alu_op        = ALU_INC;
        bundle.alu_src       = ALU_FROM_CACHE;
        bundle.loader_select = ENABLE;
        bundle.mem_addr      = ADDR_FROM_ALU;
        bundle.mem_op        = MEM_WRITE;
        bundle.pc_src        = PC_INCREMENTED;
      end
      OP_CBB: begin
        bundle.alu_op        = ALU_DEC;
        bundle.alu_src       = ALU_FROM_CACHE;
        bundle.loader_select = ENABLE;
        bundle.mem_addr      = ADDR_FROM_ALU;
        bundle.mem_op        = MEM_READ;
        // Zero accumulator clears the cache and falls through; otherwise load the branch target.
        bundle.cache_write   = acc_zero_l ? ENABLE : DISABLE;
        bundle.pc_src        = acc_zero_l ? PC_INCREMENTED : PC_LOADED;
      end
      OP_POP: begin
        bundle.alu_op        = ALU_DEC;
        bundle.alu_src       = ALU_FROM_STACK;
        bundle.mem_addr      = ADDR_FROM_HEAD;
        bundle.mem_src       = MEM_FROM_ACC;
        bundle.mem_op        = MEM_WRITE;
        bundle.pc_src        = PC_INCREMENTED;
        bundle.cache_write   = DISABLE;
      end
      default: ;
    endcase
    if (hold) bundle.cache_write = DISABLE;
  end

endmodule

// File: rtl/multi_stall_control.sv
// Multi-cycle stall sequencer: accepts a stall request from core_control and owns the datapath
// for a counted, memory-handshaked sequence of control bundles.
module multi_stall_control
  import multi_stall_control_pkg::*;
#(
  parameter int unsigned PC_BYTES  = 2,
  parameter int unsigned MAX_STALL = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_STALL + 1),
  parameter bit          WAIT_EN   = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  multi_stall_control_if.slave bus
);

  if (PC_BYTES < 2 || PC_BYTES - 1 > MAX_STALL) begin : g_param_check
    $error("multi_stall_control: PC_BYTES must be >= 2 and PC_BYTES-1 <= MAX_STALL");
  end

  stall_state_e     state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] len_q, len_d;
  op_code_e         op_q, op_d;
  logic             acc_zero_q, acc_zero_d;
  logic             seq_err_q, seq_err_d;
  logic             done;
  logic             active;
  logic             last;
  logic             mem_ready_eff;
  logic             is_stall_op;
  control_bundle_s  bundle;

  assign mem_ready_eff = WAIT_EN ? bus.mem_ready : 1'b1;
  assign active        = (state_q != SEQ_IDLE);
  assign last          = (step_q == len_q);
  assign is_stall_op   = (bus.instruction inside {OP_CBF, OP_CBB, OP_POP});

  // Next-state, step counter and request latching.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    len_d      = len_q;
    op_d       = op_q;
    acc_zero_d = acc_zero_q;
    seq_err_d  = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.stall_req && !bus.flush) begin
          if (is_stall_op) begin
            state_d    = SEQ_RUN;
            op_d       = bus.instruction;
            acc_zero_d = bus.acc_zero;
            len_d      = CNT_W'(stall_len(bus.instruction, PC_BYTES));
            step_d     = CNT_W'(1);
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      SEQ_RUN, SEQ_WAIT: begin
        if (bus.flush) begin
          state_d = SEQ_IDLE;
          step_d  = '0;
        end else begin
          seq_err_d = bus.stall_req;
          if (!mem_ready_eff) begin
            state_d = SEQ_WAIT;
          end else if (last) begin
            done    = 1'b1;
            state_d = SEQ_IDLE;
            step_d  = '0;
          end else begin
            state_d = SEQ_RUN;
            step_d  = step_q + CNT_W'(1);
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEQ_IDLE;
      step_q     <= '0;
      len_q      <= '0;
      op_q       <= OP_NOP;
      acc_zero_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      len_q      <= len_d;
      op_q       <= op_d;
      acc_zero_q <= acc_zero_d;
      seq_err_q  <= seq_err_d;
    end
  end

  stall_bundle_gen u_bundle_gen (
    .op         (op_q),
    .last       (last),
    .hold       (!mem_ready_eff || bus.flush),
    .acc_zero_l (acc_zero_q),
    .bundle     (bundle)
  );

  // Outputs; a reset on the final cycle must not report completion.
  always_comb begin
    bus.controls     = active ? bundle : IDLE_BUNDLE;
    bus.stall_active = active;
    bus.stall_done   = done && !reset;
    bus.step         = step_q;
    bus.seq_err      = seq_err_q;
  end

endmodule

// File: tb/tb_multi_stall_control.sv
// Directed bench for multi_stall_control with three instances (PC_BYTES = 2, 3, 4).
module tb_multi_stall_control;
  import multi_stall_control_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  control_bundle_s idle_exp;
  control_bundle_s cbf_last_exp;

  always #5 clk = ~clk;

  multi_stall_control_if #(.CNT_W(3)) b2 ();
  multi_stall_control_if #(.CNT_W(3)) b3 ();
  multi_stall_control_if #(.CNT_W(3)) b4 ();

  multi_stall_control #(.PC_BYTES(2), .MAX_STALL(4), .CNT_W(3), .WAIT_EN(1'b1)) u2 (
    .clk(clk), .reset(reset), .bus(b2.slave)
  );
  multi_stall_control #(.PC_BYTES(3), .MAX_STALL(4), .CNT_W(3), .WAIT_EN(1'b1)) u3 (
    .clk(clk), .reset(reset), .bus(b3.slave)
  );
  multi_stall_control #(.PC_BYTES(4), .MAX_STALL(4), .CNT_W(3), .WAIT_EN(1'b1)) u4 (
    .clk(clk), .reset(reset), .bus(b4.slave)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) next_cycle();
    #1;
    checks++;
    if (b2.controls !== idle_exp) begin
      errors++; $display("FAIL reset_controls: got %h want %h", b2.controls, idle_exp);
    end
    checks++;
    if (b4.step !== 3'd0) begin
      errors++; $display("FAIL reset_step: got %0d want 0", b4.step);
    end
    checks++;
    if ({b2.stall_active, b2.stall_done, b2.seq_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000",
                         {b2.stall_active, b2.stall_done, b2.seq_err});
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_cbf_single();
    next_cycle();
    b2.stall_req = 1'b1; b2.instruction = OP_CBF; b2.acc_zero = 1'b0; b2.mem_ready = 1'b1;
    #1;
    checks++;
    if (b2.stall_active !== 1'b0) begin
      errors++; $display("FAIL cbf_primary_active: got %b want 0", b2.stall_active);
    end
    next_cycle();
    b2.stall_req = 1'b0;
    #1;
    checks++;
    if (b2.controls !== cbf_last_exp) begin
      errors++; $display("FAIL cbf_bundle: got %h want %h", b2.controls, cbf_last_exp);
    end
    checks++;
    if ({b2.stall_active, b2.stall_done, b2.step} !== {1'b1, 1'b1, 3'd1}) begin
      errors++; $display("FAIL cbf_status: got act=%b done=%b step=%0d want 1 1 1",
                         b2.stall_active, b2.stall_done, b2.step);
    end
    next_cycle();
    checks++;
    if (b2.stall_active !== 1'b0 || b2.controls !== idle_exp) begin
      errors++; $display("FAIL cbf_return: got act=%b ctl=%h want 0 %h",
                         b2.stall_active, b2.controls, idle_exp);
    end
  endtask

  task automatic test_cbb_load();
    next_cycle();
    b4.stall_req = 1'b1; b4.instruction = OP_CBB; b4.acc_zero = 1'b0; b4.mem_ready = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      next_cycle();
      b4.stall_req = 1'b0;
      #1;
      checks++;
      if (b4.step !== 3'(s) || b4.controls.mem_op !== MEM_READ ||
          b4.controls.pc_src !== PC_LOADED || b4.controls.cache_write !== DISABLE) begin
        errors++; $display("FAIL cbb_step%0d: got step=%0d mem_op=%0d pc_src=%0d cw=%0d want %0d 1 1 0",
                           s, b4.step, b4.controls.mem_op, b4.controls.pc_src,
                           b4.controls.cache_write, s);
      end
      checks++;
      if (b4.controls.pc_write !== control_e'(s == 3) || b4.stall_done !== (s == 3) ||
          b4.controls.state !== ((s == 3) ? CORE_S : STALL_S)) begin
        errors++; $display("FAIL cbb_final%0d: got pcw=%0d done=%b st=%0d want %0d %0d %0d",
                           s, b4.controls.pc_write, b4.stall_done, b4.controls.state,
                           (s == 3), (s == 3), (s != 3));
      end
    end
    next_cycle();
    checks++;
    if (b4.stall_active !== 1'b0 || b4.step !== 3'd0) begin
      errors++; $display("FAIL cbb_return: got act=%b step=%0d want 0 0", b4.stall_active, b4.step);
    end
  endtask

  task automatic test_cbb_clear();
    next_cycle();
    b3.stall_req = 1'b1; b3.instruction = OP_CBB; b3.acc_zero = 1'b1; b3.mem_ready = 1'b1;
    next_cycle();
    b3.stall_req = 1'b0; b3.acc_zero = 1'b0;  // must use the latched value
    #1;
    checks++;
    if (b3.controls.cache_write !== ENABLE || b3.controls.pc_src !== PC_INCREMENTED ||
        b3.controls.alu_op !== ALU_DEC) begin
      errors++; $display("FAIL cbb_clear: got cw=%0d pc_src=%0d alu=%0d want 1 0 2",
                         b3.controls.cache_write, b3.controls.pc_src, b3.controls.alu_op);
    end
    next_cycle();
    checks++;
    if (b3.step !== 3'd2 || b3.stall_done !== 1'b1) begin
      errors++; $display("FAIL cbb_clear_end: got step=%0d done=%b want 2 1", b3.step, b3.stall_done);
    end
    next_cycle();
  endtask

  task automatic test_pop_wait();
    next_cycle();
    b2.stall_req = 1'b1; b2.instruction = OP_POP; b2.mem_ready = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      b2.stall_req = 1'b0; b2.mem_ready = 1'b0;
      #1;
      checks++;
      if (b2.stall_active !== 1'b1 || b2.step !== 3'd1 || b2.stall_done !== 1'b0 ||
          b2.controls.cache_write !== DISABLE || b2.controls.pc_write !== DISABLE) begin
        errors++; $display("FAIL pop_wait%0d: got act=%b step=%0d done=%b cw=%0d pcw=%0d want 1 1 0 0 0",
                           c, b2.stall_active, b2.step, b2.stall_done,
                           b2.controls.cache_write, b2.controls.pc_write);
      end
      checks++;
      if (b2.controls.mem_op !== MEM_WRITE || b2.controls.mem_addr !== ADDR_FROM_HEAD) begin
        errors++; $display("FAIL pop_wait_mem%0d: got op=%0d addr=%0d want 2 2",
                           c, b2.controls.mem_op, b2.controls.mem_addr);
      end
    end
    next_cycle();
    b2.mem_ready = 1'b1;
    #1;
    checks++;
    if (b2.controls.pc_write !== ENABLE || b2.stall_done !== 1'b1 ||
        b2.controls.alu_src !== ALU_FROM_STACK || b2.controls.mem_src !== MEM_FROM_ACC) begin
      errors++; $display("FAIL pop_done: got pcw=%0d done=%b src=%0d msrc=%0d want 1 1 2 1",
                         b2.controls.pc_write, b2.stall_done, b2.controls.alu_src,
                         b2.controls.mem_src);
    end
    next_cycle();
    checks++;
    if (b2.stall_active !== 1'b0) begin
      errors++; $display("FAIL pop_return: got act=%b want 0", b2.stall_active);
    end
  endtask

  task automatic test_flush();
    next_cycle();
    b3.stall_req = 1'b1; b3.instruction = OP_CBF; b3.mem_ready = 1'b1;
    b2.stall_req = 1'b1; b2.instruction = OP_CBF; b2.mem_ready = 1'b1;
    next_cycle();
    b3.stall_req = 1'b0; b3.flush = 1'b1;
    b2.stall_req = 1'b0; b2.flush = 1'b1;  // flush on the final step of a 1-step CBF
    #1;
    checks++;
    if (b3.step !== 3'd1 || b3.stall_done !== 1'b0 || b3.controls.pc_write !== DISABLE) begin
      errors++; $display("FAIL flush3_cycle: got step=%0d done=%b pcw=%0d want 1 0 0",
                         b3.step, b3.stall_done, b3.controls.pc_write);
    end
    checks++;
    if (b2.stall_done !== 1'b0 || b2.controls.pc_write !== DISABLE) begin
      errors++; $display("FAIL flush2_cycle: got done=%b pcw=%0d want 0 0",
                         b2.stall_done, b2.controls.pc_write);
    end
    next_cycle();
    b3.flush = 1'b0; b2.flush = 1'b0;
    #1;
    checks++;
    if (b3.stall_active !== 1'b0 || b3.step !== 3'd0 || b3.stall_done !== 1'b0 ||
        b2.stall_active !== 1'b0) begin
      errors++; $display("FAIL flush_return: got act3=%b step3=%0d done3=%b act2=%b want 0 0 0 0",
                         b3.stall_active, b3.step, b3.stall_done, b2.stall_active);
    end
  endtask

  task automatic test_seq_err();
    next_cycle();
    b4.stall_req = 1'b1; b4.instruction = OP_CBF; b4.mem_ready = 1'b1;
    next_cycle();
    b4.instruction = OP_POP;  // request while busy
    #1;
    checks++;
    if (b4.step !== 3'd1 || b4.seq_err !== 1'b0) begin
      errors++; $display("FAIL seqerr_s1: got step=%0d err=%b want 1 0", b4.step, b4.seq_err);
    end
    next_cycle();
    b4.stall_req = 1'b0;
    #1;
    checks++;
    if (b4.step !== 3'd2 || b4.seq_err !== 1'b1 || b4.controls.alu_op !== ALU_INC) begin
      errors++; $display("FAIL seqerr_busy: got step=%0d err=%b alu=%0d want 2 1 1",
                         b4.step, b4.seq_err, b4.controls.alu_op);
    end
    next_cycle();
    checks++;
    if (b4.step !== 3'd3 || b4.seq_err !== 1'b0 || b4.stall_done !== 1'b1) begin
      errors++; $display("FAIL seqerr_end: got step=%0d err=%b done=%b want 3 0 1",
                         b4.step, b4.seq_err, b4.stall_done);
    end
    next_cycle();
    b4.stall_req = 1'b1; b4.instruction = OP_ADD;
    next_cycle();
    b4.stall_req = 1'b0;
    #1;
    checks++;
    if (b4.seq_err !== 1'b1 || b4.stall_active !== 1'b0) begin
      errors++; $display("FAIL seqerr_badop: got err=%b act=%b want 1 0", b4.seq_err, b4.stall_active);
    end
    next_cycle();
    checks++;
    if (b4.seq_err !== 1'b0) begin
      errors++; $display("FAIL seqerr_pulse: got err=%b want 0", b4.seq_err);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    b4.stall_req = 1'b1; b4.instruction = OP_CBF; b4.mem_ready = 1'b1;
    next_cycle();
    b4.stall_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if (b4.step !== 3'd2 || b4.stall_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_s2: got step=%0d done=%b want 2 0", b4.step, b4.stall_done);
    end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++;
    if (b4.controls !== idle_exp || b4.step !== 3'd0 || b4.stall_active !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got ctl=%h step=%0d act=%b want %h 0 0",
                         b4.controls, b4.step, b4.stall_active, idle_exp);
    end
    next_cycle();
    checks++;
    if (b4.stall_active !== 1'b0 || b4.stall_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_stay: got act=%b done=%b want 0 0", b4.stall_active, b4.stall_done);
    end
  endtask

  initial begin
    idle_exp = '{head_write: DISABLE, stack_write: DISABLE, acc_write: DISABLE,
                 cache_write: DISABLE, pc_write: DISABLE, loader_select: DISABLE,
                 alu_op: ALU_NOP, alu_src: ALU_FROM_ACC, acc_src: ACC_FROM_ALU,
                 mem_addr: ADDR_FROM_PC, mem_src: MEM_FROM_ALU, mem_op: MEM_NOP,
                 pc_src: PC_INCREMENTED, state: CORE_S};
    cbf_last_exp = '{head_write: DISABLE, stack_write: DISABLE, acc_write: DISABLE,
                     cache_write: ENABLE, pc_write: ENABLE, loader_select: ENABLE,
                     alu_op: ALU_INC, alu_src: ALU_FROM_CACHE, acc_src: ACC_FROM_ALU,
                     mem_addr: ADDR_FROM_ALU, mem_src: MEM_FROM_ALU, mem_op: MEM_WRITE,
                     pc_src: PC_INCREMENTED, state: CORE_S};
    b2.stall_req = 1'b0; b2.instruction = OP_NOP; b2.acc_zero = 1'b0;
    b2.mem_ready = 1'b1; b2.flush = 1'b0;
    b3.stall_req = 1'b0; b3.instruction = OP_NOP; b3.acc_zero = 1'b0;
    b3.mem_ready = 1'b1; b3.flush = 1'b0;
    b4.stall_req = 1'b0; b4.instruction = OP_NOP; b4.acc_zero = 1'b0;
    b4.mem_ready = 1'b1; b4.flush = 1'b0;

    test_reset();
    test_cbf_single();
    test_cbb_load();
    test_cbb_clear();
    test_pop_wait();
    test_flush();
    test_seq_err();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
